logic_op_arbiter: RTL and testbench

Shares one bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) between NREQ requesters. Each requester issues an opcode and two operands over a valid/ready handshake. A round-robin arbiter grants one request per cycle and returns a registered, tagged result on a single valid/ready response channel. The block sits between the requesting control blocks and the shared gate datapath.

---
 rtl/logic_op_pkg.sv | 13 +
 rtl/logic_op_unit.sv | 31 +++
 rtl/logic_op_arbiter.sv | 95 +++++++++
 tb/tb_logic_op_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared opcode encodings for the bitwise logic unit and its arbiter.
package logic_op_pkg;
    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_AND  = 3'd0;
    localparam logic [OPW-1:0] OP_OR   = 3'd1;
    localparam logic [OPW-1:0] OP_NOT  = 3'd2;
    localparam logic [OPW-1:0] OP_NAND = 3'd3;
    localparam logic [OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [OPW-1:0] OP_XOR  = 3'd5;
    localparam logic [OPW-1:0] OP_XNOR = 3'd6;
    localparam logic [OPW-1:0] OP_RSVD = 3'd7;
endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise gate datapath; reserved opcode yields zero data and an error flag.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             err
);
    // Decode the opcode into one bitwise function of a and b.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op)
            OP_AND:  data = a & b;
            OP_OR:   data = a | b;
            OP_NOT:  data = ~a;
            OP_NAND: data = ~(a & b);
            OP_NOR:  data = ~(a | b);
            OP_XOR:  data = a ^ b;
            OP_XNOR: data = ~(a ^ b);
            default: begin
                data = '0;
                err  = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit among NREQ requesters,
// with a single registered, tagged response slot.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPW*NREQ-1:0]   req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [OPW-1:0]        rsp_op,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err
);
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt;
    logic             gnt_found;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] fu_data;
    logic             fu_err;
    logic             accept;
    logic             handshake;

    // The slot can take a new result when empty or draining this cycle.
    assign accept    = !rsp_valid || rsp_ready;
    assign handshake = gnt_found && accept && !rst;

    // Scan from rr_ptr upward with wrap at NREQ-1; first valid requester wins
    // and its operands are steered to the shared unit.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt       = IDW'(idx);
                sel_op    = req_op[idx*OPW +: OPW];
                sel_a     = req_a[idx*WIDTH +: WIDTH];
                sel_b     = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready to the granted requester only when the slot can load.
    always_comb begin
        req_ready = '0;
        if (handshake) req_ready[gnt] = 1'b1;
    end

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op   (sel_op),
        .a    (sel_a),
        .b    (sel_b),
        .data (fu_data),
        .err  (fu_err)
    );

    // Response register and round-robin pointer; pointer moves only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_op    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= '0;
        end else if (handshake) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt;
            rsp_op    <= sel_op;
            rsp_data  <= fu_data;
            rsp_err   <= fu_err;
            rr_ptr    <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed, table-driven bench for logic_op_arbiter (NREQ=4, WIDTH=8).
module tb_logic_op_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2:0]            rsp_op;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;

    int tests  = 0;
    int errors = 0;

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_op    (rsp_op),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_rv;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] valid, logic [2:0] op, logic [7:0] a, logic [7:0] b,
                                logic rdy, logic [3:0] er, logic rv, logic [1:0] id,
                                logic [7:0] d, logic e);
        vec_t v;
        v.valid = valid; v.op = op; v.a = a; v.b = b; v.rdy = rdy;
        v.exp_ready = er; v.exp_rv = rv; v.exp_id = id; v.exp_data = d; v.exp_err = e;
        return v;
    endfunction

    task automatic drive(logic [3:0] valid, logic [2:0] op, logic [7:0] a, logic [7:0] b, logic rdy);
        req_valid = valid;
        req_op    = {NREQ{op}};
        req_a     = {NREQ{a}};
        req_b     = {NREQ{b}};
        rsp_ready = rdy;
    endtask

    task automatic chk_ready(string name, logic [3:0] exp);
        tests++;
        if (req_ready !== exp) begin
            errors++;
            $display("FAIL %s req_ready got %b want %b", name, req_ready, exp);
        end
    endtask

    task automatic chk_rsp(string name, logic rv, logic [1:0] id, logic [7:0] d, logic e);
        tests++;
        if (rsp_valid !== rv || rsp_id !== id || rsp_data !== d || rsp_err !== e) begin
            errors++;
            $display("FAIL %s rsp got v=%b id=%0d d=%h e=%b want v=%b id=%0d d=%h e=%b",
                     name, rsp_valid, rsp_id, rsp_data, rsp_err, rv, id, d, e);
        end
    endtask

    initial begin
        // Fairness with all valid, first grant after reset is requester 0
        vecs.push_back(mk(4'b1111, 3'd0, 8'hF0, 8'h3C, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h30, 1'b0));
        vecs.push_back(mk(4'b1111, 3'd1, 8'hF0, 8'h3C, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hFC, 1'b0));
        vecs.push_back(mk(4'b1111, 3'd5, 8'hF0, 8'h3C, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hCC, 1'b0));
        vecs.push_back(mk(4'b1111, 3'd3, 8'hF0, 8'h3C, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hCF, 1'b0));
        vecs.push_back(mk(4'b1111, 3'd4, 8'hF0, 8'h3C, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h03, 1'b0));
        vecs.push_back(mk(4'b1111, 3'd6, 8'hF0, 8'h3C, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h33, 1'b0));
        // req1 dropped: sequence 2,3,0,2
        vecs.push_back(mk(4'b1101, 3'd2, 8'hF0, 8'h3C, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h0F, 1'b0));
        vecs.push_back(mk(4'b1101, 3'd0, 8'hF0, 8'h3C, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h30, 1'b0));
        vecs.push_back(mk(4'b1101, 3'd1, 8'hF0, 8'h3C, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hFC, 1'b0));
        vecs.push_back(mk(4'b1101, 3'd5, 8'hF0, 8'h3C, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hCC, 1'b0));
        // Idle drain: valid drops, other fields hold
        vecs.push_back(mk(4'b0000, 3'd0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hCC, 1'b0));
        // Single request from req0 (rr_ptr=3 wraps to 0)
        vecs.push_back(mk(4'b0001, 3'd0, 8'hF0, 8'h3C, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h30, 1'b0));
        // Op sweep on req2
        vecs.push_back(mk(4'b0100, 3'd0, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h05, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd1, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hAF, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd2, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd3, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hFA, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd4, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h50, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd5, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hAA, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd6, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b0));
        vecs.push_back(mk(4'b0100, 3'd7, 8'hA5, 8'h0F, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h00, 1'b1));
        // Backpressure: 3 stalled cycles hold the reserved-op response
        vecs.push_back(mk(4'b1111, 3'd0, 8'hFF, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1));
        vecs.push_back(mk(4'b1111, 3'd0, 8'hFF, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1));
        vecs.push_back(mk(4'b1111, 3'd0, 8'hFF, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1));
        // Drain plus same-cycle grant to rr_ptr=3
        vecs.push_back(mk(4'b1111, 3'd6, 8'hA5, 8'h0F, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h55, 1'b0));
        vecs.push_back(mk(4'b1111, 3'd0, 8'hF0, 8'h3C, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h30, 1'b0));
        // Stall with rr_ptr=1, then reset below
        vecs.push_back(mk(4'b1111, 3'd1, 8'h11, 8'h22, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h30, 1'b0));

        // Reset held 2 cycles with all requesters valid
        rst = 1'b1;
        drive(4'b1111, 3'd0, 8'hF0, 8'h3C, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_ready("reset_ready", 4'b0000);
            @(posedge clk); #1;
            chk_rsp("reset_rsp", 1'b0, 2'd0, 8'h00, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdy);
            #1;
            chk_ready($sformatf("vec%0d_ready", i), vecs[i].exp_ready);
            @(posedge clk); #1;
            chk_rsp($sformatf("vec%0d_rsp", i), vecs[i].exp_rv, vecs[i].exp_id,
                    vecs[i].exp_data, vecs[i].exp_err);
            @(negedge clk);
        end

        // Reset mid-stall discards the held response and rr_ptr
        rst = 1'b1;
        drive(4'b1111, 3'd1, 8'h11, 8'h22, 1'b0);
        #1;
        chk_ready("midrst_ready", 4'b0000);
        @(posedge clk); #1;
        chk_rsp("midrst_rsp", 1'b0, 2'd0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1111, 3'd1, 8'h11, 8'h22, 1'b1);
        #1;
        chk_ready("post_rst_ready", 4'b0001);
        @(posedge clk); #1;
        chk_rsp("post_rst_rsp", 1'b1, 2'd0, 8'h33, 1'b0);
        @(negedge clk);
        drive(4'b0000, 3'd0, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk_rsp("final_drain", 1'b0, 2'd0, 8'h33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
